// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Definitions shared by the bit-serial adder controller:
//   ST_IDLE / ST_RUN / ST_DONE : FSM state encodings
//   cnt_width()                : width of the bit counter for a given WIDTH
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A 1-bit operand still needs a 1-bit counter, so clamp at 1.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned w;
        if (width > 32'd1) begin
            w = $clog2(width);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// ---------------------------------------------------------------------------
// fulladder
// One-bit full adder; the only arithmetic element of the serial adder.
// Ports:
//   a_i, b_i, cin_i : addend bits and carry-in
//   sum_o           : a ^ b ^ cin
//   cout_o          : majority(a, b, cin)
// ---------------------------------------------------------------------------
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Adds A + B + cin one bit per clock, LSB first, through a single full adder.
// Parameter:
//   WIDTH     : operand / sum width (1..32)
// Ports:
//   i_w_clk   : clock, rising edge
//   i_w_reset : synchronous active-high reset
//   i_w_start : start request, honoured only in IDLE
//   i_w_a/b   : operands, captured when start is accepted
//   i_w_cin   : carry-in, captured when start is accepted
//   o_w_busy  : high while the addition is in progress
//   o_w_done  : one-cycle pulse, sum and carry are valid
//   o_w_sum   : registered sum (WIDTH bits)
//   o_w_cout  : registered final carry-out
// ---------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_w_clk,
    input  logic             i_w_reset,
    input  logic             i_w_start,
    input  logic [WIDTH-1:0] i_w_a,
    input  logic [WIDTH-1:0] i_w_b,
    input  logic             i_w_cin,
    output logic             o_w_busy,
    output logic             o_w_done,
    output logic [WIDTH-1:0] o_w_sum,
    output logic             o_w_cout
);

    localparam int unsigned          CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] sum_shift_s;

    fulladder u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum_s),
        .cout_o (fa_cout_s)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the first bit sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign sum_shift_s = fa_sum_s;
        end else begin : g_shift_wn
            assign sum_shift_s = {fa_sum_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state and datapath update for IDLE / RUN / DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_w_start) begin
                    state_d = ST_RUN;
                    a_d     = i_w_a;
                    b_d     = i_w_b;
                    carry_d = i_w_cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                sum_d   = sum_shift_s;
                carry_d = fa_cout_s;
                a_d     = a_q >> 1'b1;
                b_d     = b_q >> 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Last bit: publish carry and raise done together with the final sum.
                    state_d = ST_DONE;
                    cout_d  = fa_cout_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_w_busy = busy_q;
    assign o_w_done = done_q;
    assign o_w_sum  = sum_q;
    assign o_w_cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed bench for serial_adder_ctrl with an 8-bit and a 1-bit instance.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .i_w_start (start8),
        .i_w_a     (a8),
        .i_w_b     (b8),
        .i_w_cin   (cin8),
        .o_w_busy  (busy8),
        .o_w_done  (done8),
        .o_w_sum   (sum8),
        .o_w_cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .i_w_start (start1),
        .i_w_a     (a1),
        .i_w_b     (b1),
        .i_w_cin   (cin1),
        .o_w_busy  (busy1),
        .o_w_done  (done1),
        .o_w_sum   (sum1),
        .o_w_cout  (cout1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; intr != 0 re-asserts start with new operands before edge k+intr.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input int intr);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        step();
        start8 = 1'b0;
        check("accept_busy", {31'd0, busy8}, 32'd1);
        check("accept_done", {31'd0, done8}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            if (i == intr) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
            end
            step();
            start8 = 1'b0;
            if (i < 8) begin
                check("run_busy", {31'd0, busy8}, 32'd1);
                check("run_done", {31'd0, done8}, 32'd0);
            end else begin
                check("done_high", {31'd0, done8}, 32'd1);
                check("done_busy", {31'd0, busy8}, 32'd0);
                check("sum", {24'd0, sum8}, {24'd0, es});
                check("cout", {31'd0, cout8}, {31'd0, ec});
            end
        end
        step();
        check("done_pulse_end", {31'd0, done8}, 32'd0);
        check("sum_hold", {24'd0, sum8}, {24'd0, es});
    endtask

    initial begin
        int t_done[3];
        int nd;
        logic [7:0] ea[3];
        logic [7:0] eb[3];
        logic       ec_in[3];
        logic [7:0] es[3];
        logic       eco[3];
        logic [1:0] tot;

        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
        step();
        step();
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_sum",  {24'd0, sum8}, 32'd0);
        check("rst_cout", {31'd0, cout8}, 32'd0);
        rst = 1'b0;

        // First start right after reset release, then overflow cases.
        run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        // Start while busy at edge k+3 must be ignored; operands also change mid-run.
        run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);
        step();
        check("no_requeue_busy", {31'd0, busy8}, 32'd0);

        // Reset in the middle of a run.
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy8}, 32'd0);
        check("midrst_done", {31'd0, done8}, 32'd0);
        check("midrst_sum",  {24'd0, sum8}, 32'd0);
        check("midrst_cout", {31'd0, cout8}, 32'd0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done8) nd++;
        end
        check("midrst_no_done", nd, 32'd0);
        run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);

        // Back-to-back with start held; next operands presented when each done appears.
        ea[0] = 8'h10; eb[0] = 8'h20; ec_in[0] = 1'b0; es[0] = 8'h30; eco[0] = 1'b0;
        ea[1] = 8'h80; eb[1] = 8'h80; ec_in[1] = 1'b0; es[1] = 8'h00; eco[1] = 1'b1;
        ea[2] = 8'h7F; eb[2] = 8'h01; ec_in[2] = 1'b1; es[2] = 8'h81; eco[2] = 1'b0;
        start8 = 1'b1; a8 = ea[0]; b8 = eb[0]; cin8 = ec_in[0];
        nd = 0;
        for (int t = 1; t <= 40; t++) begin
            step();
            if (done8 && nd < 3) begin
                t_done[nd] = t;
                check("b2b_sum",  {24'd0, sum8}, {24'd0, es[nd]});
                check("b2b_cout", {31'd0, cout8}, {31'd0, eco[nd]});
                nd++;
                if (nd < 3) begin
                    a8 = ea[nd]; b8 = eb[nd]; cin8 = ec_in[nd];
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        check("b2b_count", nd, 32'd3);
        if (nd == 3) begin
            check("b2b_gap1", t_done[1] - t_done[0], 32'd10);
            check("b2b_gap2", t_done[2] - t_done[1], 32'd10);
        end

        // WIDTH=1 exhaustive.
        for (int v = 0; v < 8; v++) begin
            a1[0] = v[2]; b1[0] = v[1]; cin1 = v[0];
            tot = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            check("w1_busy", {31'd0, busy1}, 32'd1);
            check("w1_early_done", {31'd0, done1}, 32'd0);
            step();
            check("w1_done", {31'd0, done1}, 32'd1);
            check("w1_result", {30'd0, cout1, sum1[0]}, {30'd0, tot});
            step();
            check("w1_done_end", {31'd0, done1}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
